dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder end of the core's data-memory port: accepts the word address, write data and write enable driven by the pipeline MEM stage, and returns read data one cycle later.
- Decodes the word address into two regions:
  - on-chip data RAM;
  - a small MMIO register window (LED register, free-running cycle counter, tohost/halt mailbox).
- Sits at SoC level between the core's data port and the board outputs.

Parameters:
- DATA_WIDTH, 32, width of data words and MMIO registers.
- DATA_MEM_ADDR_WIDTH, 12, word-address width; MSB selects the region, so the RAM holds 2^(DATA_MEM_ADDR_WIDTH-1) words.
- LED_WIDTH, 8, number of LED output bits (must be ≤ DATA_WIDTH).

Ports:
- i_clk  input  1  single clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_addr  input  DATA_MEM_ADDR_WIDTH  word address from core MEM stage.
- i_wrdata  input  DATA_WIDTH  write data.
- i_we  input  1  write enable; sampled at the rising edge.
- o_rdata  output  DATA_WIDTH  registered read data, valid the cycle after the address is presented.
- o_led  output  LED_WIDTH  LED register, low bits.
- o_halt  output  1  sticky halt flag.
- o_tohost  output  DATA_WIDTH  last value written to TOHOST.

Behaviour:
- Clocking and reset:
  - One clock (i_clk); reset is asynchronous, active-low (i_rst_n).
  - Reset values: o_rdata=0, LED reg=0, cycle counter=0, o_halt=0, o_tohost=0.
  - RAM contents are not reset.
- Region decode on i_addr:
  - MSB=0: RAM, index = i_addr[DATA_MEM_ADDR_WIDTH-2:0].
  - MSB=1: MMIO, offset = i_addr[1:0]; remaining address bits are ignored, so the window aliases.
- MMIO map (offset: register):
  - 0 LED: RW. o_led = reg[LED_WIDTH-1:0]; reads return the full DATA_WIDTH register.
  - 1 CYCLE: counter increments by 1 every cycle and wraps at 2^DATA_WIDTH-1 → 0. A write loads i_wrdata; the counter then resumes incrementing from that value the next cycle (no increment on the write cycle).
  - 2 TOHOST: RW. A write stores i_wrdata and sets o_halt=1 from the next cycle. Reads return the stored value.
  - 3 STATUS: RO. Returns {zeros, o_halt} in bit 0. Writes are ignored.
- Read latency:
  - Exactly 1 cycle. Address presented in cycle N → o_rdata valid in cycle N+1 and held until the next edge.
  - The region select and MMIO offset are registered alongside the RAM read, and the output mux uses those registered copies.
- Read-during-write, same address, same cycle:
  - RAM is read-first: o_rdata returns the old word.
  - MMIO also returns the pre-write value (CYCLE: the pre-load counter value).
- Writes:
  - Take effect at the edge where i_we=1; there is no partial or byte write.
  - Reads happen every cycle regardless of i_we.
- o_halt:
  - Sticky; cleared only by reset.
  - A second TOHOST write updates o_tohost and leaves o_halt=1.
- Reset mid-operation: the async assert forces all registered outputs to their reset values immediately; a write in flight at that edge is dropped for MMIO (RAM unaffected).
- No stalls, no handshake: the core must tolerate a fixed 1-cycle latency.

Test Plan:
- RAM write/read:
  - Write 0xDEADBEEF @0x005, then read @0x005.
  - o_rdata=0xDEADBEEF exactly one cycle after the read address.
  - Read @0x006 after writing 0x12345678 there → 0x12345678 (no cross-talk).
- Read-first collision:
  - Write 0x11111111 @0x010.
  - Next cycle, write 0x22222222 @0x010 with the same address presented.
  - o_rdata=0x11111111; a following read → 0x22222222.
- LED and aliasing:
  - Write 0xA5A5A5F3 @0x800 → o_led=0xF3 next cycle.
  - Read @0x804 (alias of offset 0) → 0xA5A5A5F3.
  - Write to STATUS @0x803 → no state change.
- Cycle counter:
  - Read @0x801 on two cycles 10 apart → difference 10.
  - Write 0xFFFFFFFE → reads on the next cycles return 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Halt:
  - Write 0x00000001 @0x802 → o_halt=1 and o_tohost=1 next cycle; read @0x803 → 0x1.
  - Write 0x2 @0x802 → o_tohost=2, o_halt stays 1.
- Async reset:
  - Assert i_rst_n=0 mid-cycle with o_halt=1, LED=0xFF.
  - All outputs go to 0 without waiting for a clock edge; the counter restarts from 0 after release.
  - RAM @0x005 still reads 0xDEADBEEF.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: on-chip RAM plus a small MMIO window (LED, cycle counter,
// tohost/halt mailbox) with a fixed one-cycle read latency.
module dmem_responder #(
  parameter int DATA_WIDTH          = 32,
  parameter int DATA_MEM_ADDR_WIDTH = 12,
  parameter int LED_WIDTH           = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]          i_wrdata,
  input  logic                           i_we,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic [LED_WIDTH-1:0]           o_led,
  output logic                           o_halt,
  output logic [DATA_WIDTH-1:0]          o_tohost
);

  localparam int RAM_AW    = DATA_MEM_ADDR_WIDTH - 1;
  localparam int RAM_WORDS = 1 << RAM_AW;

  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_CYCLE  = 2'd1;
  localparam logic [1:0] OFF_TOHOST = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  logic [DATA_WIDTH-1:0] ram_mem [RAM_WORDS];
  logic [DATA_WIDTH-1:0] ram_rd_q;

  logic                  is_mmio_s;
  logic [RAM_AW-1:0]     ram_idx_s;
  logic [1:0]            mmio_off_s;
  logic                  mmio_we_s;
  logic                  ram_we_s;

  logic [DATA_WIDTH-1:0] led_q, led_d;
  logic [DATA_WIDTH-1:0] cycle_q, cycle_d;
  logic [DATA_WIDTH-1:0] tohost_q, tohost_d;
  logic                  halt_q, halt_d;
  logic [DATA_WIDTH-1:0] mmio_rd_q, mmio_rd_d;
  logic                  rd_mmio_q;

  assign is_mmio_s  = i_addr[DATA_MEM_ADDR_WIDTH-1];
  assign ram_idx_s  = i_addr[RAM_AW-1:0];
  assign mmio_off_s = i_addr[1:0];
  assign mmio_we_s  = i_we & is_mmio_s;
  assign ram_we_s   = i_we & ~is_mmio_s;

  // RAM array: read-first, contents deliberately not reset.
  always_ff @(posedge i_clk) begin
    ram_rd_q <= ram_mem[ram_idx_s];
    if (ram_we_s) begin
      ram_mem[ram_idx_s] <= i_wrdata;
    end
  end

  // MMIO next-state and read snapshot; the snapshot uses pre-write values.
  always_comb begin
    led_d     = led_q;
    cycle_d   = cycle_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    tohost_d  = tohost_q;
    halt_d    = halt_q;
    mmio_rd_d = {DATA_WIDTH{1'b0}};

    case (mmio_off_s)
      OFF_LED:    mmio_rd_d = led_q;
      OFF_CYCLE:  mmio_rd_d = cycle_q;
      OFF_TOHOST: mmio_rd_d = tohost_q;
      OFF_STATUS: mmio_rd_d = {{(DATA_WIDTH-1){1'b0}}, halt_q};
      default:    mmio_rd_d = {DATA_WIDTH{1'b0}};
    endcase

    if (mmio_we_s) begin
      case (mmio_off_s)
        OFF_LED:    led_d = i_wrdata;
        OFF_CYCLE:  cycle_d = i_wrdata;
        OFF_TOHOST: begin
          tohost_d = i_wrdata;
          halt_d   = 1'b1;
        end
        OFF_STATUS: halt_d = halt_q;
        default:    halt_d = halt_q;
      endcase
    end else begin
      halt_d = halt_q;
    end
  end

  // MMIO registers and the registered read-path select.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      led_q     <= {DATA_WIDTH{1'b0}};
      cycle_q   <= {DATA_WIDTH{1'b0}};
      tohost_q  <= {DATA_WIDTH{1'b0}};
      halt_q    <= 1'b0;
      mmio_rd_q <= {DATA_WIDTH{1'b0}};
      rd_mmio_q <= 1'b1;
    end else begin
      led_q     <= led_d;
      cycle_q   <= cycle_d;
      tohost_q  <= tohost_d;
      halt_q    <= halt_d;
      mmio_rd_q <= mmio_rd_d;
      rd_mmio_q <= is_mmio_s;
    end
  end

  // Reset parks the select on the zeroed MMIO snapshot so o_rdata reads 0 at once.
  assign o_rdata  = rd_mmio_q ? mmio_rd_q : ram_rd_q;
  assign o_led    = led_q[LED_WIDTH-1:0];
  assign o_halt   = halt_q;
  assign o_tohost = tohost_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed plan plus randomized traffic
// compared every cycle against a behavioural model.
module tb_dmem_responder;

  logic        i_clk;
  logic        i_rst_n;
  logic [11:0] i_addr;
  logic [31:0] i_wrdata;
  logic        i_we;
  logic [31:0] o_rdata;
  logic [7:0]  o_led;
  logic        o_halt;
  logic [31:0] o_tohost;

  int errors;
  int checks;

  dmem_responder #(
    .DATA_WIDTH(32),
    .DATA_MEM_ADDR_WIDTH(12),
    .LED_WIDTH(8)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_addr   (i_addr),
    .i_wrdata (i_wrdata),
    .i_we     (i_we),
    .o_rdata  (o_rdata),
    .o_led    (o_led),
    .o_halt   (o_halt),
    .o_tohost (o_tohost)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural model: register values, RAM array, and the counter expressed as
  // "value loaded at edge t0 plus edges elapsed since".
  logic [31:0] m_ram [2048];
  bit          m_ramv [2048];
  logic [31:0] m_led, m_tohost, m_rdata;
  logic        m_halt, m_rvalid;
  logic [31:0] m_edge, m_t0, m_base;

  function automatic logic [31:0] cnt_now();
    return m_base + (m_edge - m_t0);
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_led    <= 32'd0;
      m_tohost <= 32'd0;
      m_halt   <= 1'b0;
      m_rdata  <= 32'd0;
      m_rvalid <= 1'b1;
      m_edge   <= 32'd0;
      m_t0     <= 32'd0;
      m_base   <= 32'd0;
    end else begin
      m_edge <= m_edge + 32'd1;
      if (!i_addr[11]) begin
        m_rdata  <= m_ram[i_addr[10:0]];
        m_rvalid <= m_ramv[i_addr[10:0]];
        if (i_we) begin
          m_ram[i_addr[10:0]]  <= i_wrdata;
          m_ramv[i_addr[10:0]] <= 1'b1;
        end
      end else begin
        m_rvalid <= 1'b1;
        case (i_addr[1:0])
          2'd0:    m_rdata <= m_led;
          2'd1:    m_rdata <= cnt_now();
          2'd2:    m_rdata <= m_tohost;
          default: m_rdata <= {31'd0, m_halt};
        endcase
        if (i_we) begin
          case (i_addr[1:0])
            2'd0: m_led <= i_wrdata;
            2'd1: begin
              m_base <= i_wrdata;
              m_t0   <= m_edge + 32'd1;
            end
            2'd2: begin
              m_tohost <= i_wrdata;
              m_halt   <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_compare();
    chk("led", {24'd0, o_led}, {24'd0, m_led[7:0]});
    chk("halt", {31'd0, o_halt}, {31'd0, m_halt});
    chk("tohost", o_tohost, m_tohost);
    if (m_rvalid) chk("rdata", o_rdata, m_rdata);
  endtask

  // One bus cycle: drive at negedge, let the edge happen, check at next negedge.
  task automatic step(input logic [11:0] a, input logic [31:0] d, input logic we);
    i_addr   = a;
    i_wrdata = d;
    i_we     = we;
    @(posedge i_clk);
    @(negedge i_clk);
    model_compare();
  endtask

  logic [31:0] r1, r2;
  logic [11:0] ra;

  initial begin
    errors   = 0;
    checks   = 0;
    i_rst_n  = 1'b0;
    i_addr   = 12'h803;
    i_wrdata = 32'd0;
    i_we     = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_led", {24'd0, o_led}, 32'd0);
    chk("rst_halt", {31'd0, o_halt}, 32'd0);
    chk("rst_tohost", o_tohost, 32'd0);
    i_rst_n = 1'b1;

    // RAM write/read and no cross-talk
    step(12'h005, 32'hDEADBEEF, 1'b1);
    step(12'h006, 32'h12345678, 1'b1);
    step(12'h005, 32'h0, 1'b0);
    chk("ram_rd5", o_rdata, 32'hDEADBEEF);
    step(12'h006, 32'h0, 1'b0);
    chk("ram_rd6", o_rdata, 32'h12345678);

    // Read-first collision
    step(12'h010, 32'h11111111, 1'b1);
    step(12'h010, 32'h22222222, 1'b1);
    chk("rf_old", o_rdata, 32'h11111111);
    step(12'h010, 32'h0, 1'b0);
    chk("rf_new", o_rdata, 32'h22222222);

    // LED, aliasing, STATUS write ignored
    step(12'h800, 32'hA5A5A5F3, 1'b1);
    chk("led_f3", {24'd0, o_led}, 32'h000000F3);
    step(12'h804, 32'h0, 1'b0);
    chk("led_alias", o_rdata, 32'hA5A5A5F3);
    step(12'h803, 32'hFFFFFFFF, 1'b1);
    chk("status_rd", o_rdata, 32'd0);
    step(12'h803, 32'h0, 1'b0);
    chk("status_wr_ign", {31'd0, o_halt}, 32'd0);
    step(12'h800, 32'h0, 1'b0);
    chk("led_after_st", o_rdata, 32'hA5A5A5F3);

    // Cycle counter delta and wrap
    step(12'h801, 32'h0, 1'b0);
    r1 = o_rdata;
    for (int i = 0; i < 9; i++) step(12'h803, 32'h0, 1'b0);
    step(12'h801, 32'h0, 1'b0);
    r2 = o_rdata;
    chk("cyc_delta", r2 - r1, 32'd10);
    step(12'h801, 32'hFFFFFFFE, 1'b1);
    step(12'h801, 32'h0, 1'b0);
    chk("cyc_fffe", o_rdata, 32'hFFFFFFFE);
    step(12'h801, 32'h0, 1'b0);
    chk("cyc_ffff", o_rdata, 32'hFFFFFFFF);
    step(12'h801, 32'h0, 1'b0);
    chk("cyc_wrap", o_rdata, 32'h00000000);

    // Halt mailbox
    step(12'h802, 32'h1, 1'b1);
    chk("halt_set", {31'd0, o_halt}, 32'd1);
    chk("tohost1", o_tohost, 32'd1);
    step(12'h803, 32'h0, 1'b0);
    chk("status_halt", o_rdata, 32'd1);
    step(12'h802, 32'h2, 1'b1);
    chk("tohost2", o_tohost, 32'd2);
    chk("halt_sticky", {31'd0, o_halt}, 32'd1);

    // Async reset mid-cycle
    step(12'h800, 32'hFF, 1'b1);
    chk("led_ff", {24'd0, o_led}, 32'h000000FF);
    i_addr = 12'h803;
    i_we   = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_rdata", o_rdata, 32'd0);
    chk("arst_led", {24'd0, o_led}, 32'd0);
    chk("arst_halt", {31'd0, o_halt}, 32'd0);
    chk("arst_tohost", o_tohost, 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(12'h801, 32'h0, 1'b0);
    chk("cyc_restart0", o_rdata, 32'd0);
    step(12'h801, 32'h0, 1'b0);
    chk("cyc_restart1", o_rdata, 32'd1);
    step(12'h005, 32'h0, 1'b0);
    chk("ram_survives", o_rdata, 32'hDEADBEEF);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0)
        ra = {1'b0, 7'd0, 4'($urandom_range(0, 15))};
      else if ($urandom_range(0, 3) == 0)
        ra = {1'b0, 11'($urandom)};
      else
        ra = {1'b1, 11'($urandom)};
      step(ra, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
